// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN streaming pipeline stages.
package cnn_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_MAP_SIZE   = 16;
  localparam int CNT_W              = $clog2(DEFAULT_MAP_SIZE);

  // Widest operand the compare helper handles; callers zero-extend into it.
  localparam int MAX_W = 32;

  // Unsigned maximum of two activations.
  function automatic logic [MAX_W-1:0] max2(input logic [MAX_W-1:0] a,
                                            input logic [MAX_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pool_line_buf.sv
// Half-row buffer of partial maxima from the top row of each 2x2 window.
module pool_line_buf
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int DEPTH      = DEFAULT_MAP_SIZE / 2,
  parameter int AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [AW-1:0]         rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Single write port; the whole array clears on reset so no stale maxima survive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Combinational read so the bottom-right pixel can be pooled in its accept cycle.
  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/max_pool_stream.sv
// Streaming 2x2 / stride-2 max-pool with valid/ready backpressure.
module max_pool_stream
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int MAP_SIZE   = DEFAULT_MAP_SIZE
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  frame_clr,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last
);

  localparam int CNT_BITS = $clog2(MAP_SIZE);
  localparam int LB_DEPTH = MAP_SIZE / 2;
  localparam int LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;
  localparam logic [CNT_BITS-1:0] LAST_IDX = CNT_BITS'(MAP_SIZE - 1);

  if (MAP_SIZE < 2 || (MAP_SIZE % 2) != 0) begin : g_bad_map_size
    $error("max_pool_stream: MAP_SIZE must be even and >= 2");
  end

  logic [CNT_BITS-1:0]   row;
  logic [CNT_BITS-1:0]   col;
  logic [DATA_WIDTH-1:0] hold;
  logic [DATA_WIDTH-1:0] lbuf_rdata;
  logic [DATA_WIDTH-1:0] top_max;
  logic [DATA_WIDTH-1:0] win_max;
  logic [LB_AW-1:0]      lbuf_addr;
  logic                  accept;
  logic                  lbuf_we;
  logic                  window_done;

  // One output register, so the whole stage stalls whenever it is full and not drained.
  assign in_ready    = !out_valid || out_ready;
  assign accept      = in_valid && in_ready && !frame_clr;
  assign lbuf_addr   = LB_AW'(col >> 1);
  assign lbuf_we     = accept && !row[0] && col[0];
  assign window_done = accept && row[0] && col[0];

  assign top_max = DATA_WIDTH'(max2(MAX_W'(hold), MAX_W'(in_data)));
  assign win_max = DATA_WIDTH'(max2(MAX_W'(lbuf_rdata), MAX_W'(top_max)));

  pool_line_buf #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (LB_DEPTH),
    .AW        (LB_AW)
  ) u_line_buf (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (lbuf_we),
    .wr_addr(lbuf_addr),
    .wr_data(top_max),
    .rd_addr(lbuf_addr),
    .rd_data(lbuf_rdata)
  );

  // Raster position and the left-pixel hold register; frame_clr wins over an accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row  <= '0;
      col  <= '0;
      hold <= '0;
    end else if (frame_clr) begin
      row  <= '0;
      col  <= '0;
      hold <= '0;
    end else if (accept) begin
      if (!col[0]) begin
        hold <= in_data;
      end
      if (col == LAST_IDX) begin
        col <= '0;
        row <= (row == LAST_IDX) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Output register: loads on a completed window, otherwise drains on out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (window_done) begin
      out_valid <= 1'b1;
      out_data  <= win_max;
      out_last  <= (row == LAST_IDX) && (col == LAST_IDX);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_max_pool_stream.sv
// Bench for max_pool_stream: a frame-buffer reference model plus directed scenarios.
module tb_max_pool_stream;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_clr = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic       out_ready = 1'b1;
  logic       big = 1'b0;
  logic       rand_ready = 1'b0;
  logic       rand_gap = 1'b0;

  logic       in_valid4, in_ready4, out_valid4, out_last4;
  logic [7:0] out_data4;
  logic       in_valid16, in_ready16, out_valid16, out_last16;
  logic [7:0] out_data16;

  logic       cur_in_ready, cur_out_valid, cur_out_last;
  logic [7:0] cur_out_data;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  // Reference model state: whole-frame pixel store and the expected output register.
  int   frame_px [256];
  int   pix_cnt = 0;
  logic exp_valid = 1'b0;
  int   exp_data = 0;
  logic exp_last = 1'b0;

  int   got_d [$];
  logic got_l [$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign in_valid4  = in_valid && !big;
  assign in_valid16 = in_valid && big;

  assign cur_in_ready  = big ? in_ready16  : in_ready4;
  assign cur_out_valid = big ? out_valid16 : out_valid4;
  assign cur_out_data  = big ? out_data16  : out_data4;
  assign cur_out_last  = big ? out_last16  : out_last4;

  max_pool_stream #(.DATA_WIDTH(8), .MAP_SIZE(4)) u_dut4 (
    .clk      (clk),
    .rst_n    (rst_n),
    .frame_clr(frame_clr),
    .in_valid (in_valid4),
    .in_ready (in_ready4),
    .in_data  (in_data),
    .out_valid(out_valid4),
    .out_ready(out_ready),
    .out_data (out_data4),
    .out_last (out_last4)
  );

  max_pool_stream #(.DATA_WIDTH(8), .MAP_SIZE(16)) u_dut16 (
    .clk      (clk),
    .rst_n    (rst_n),
    .frame_clr(frame_clr),
    .in_valid (in_valid16),
    .in_ready (in_ready16),
    .in_data  (in_data),
    .out_valid(out_valid16),
    .out_ready(out_ready),
    .out_data (out_data16),
    .out_last (out_last16)
  );

  task automatic check_output(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare process: checks the DUT every mid-cycle, then advances the model for the next edge.
  always @(negedge clk) begin
    int   n, r, c, m;
    logic acc;
    if (!rst_n) begin
      check_output("rst_out_valid", int'(cur_out_valid), 0);
      check_output("rst_out_data", int'(cur_out_data), 0);
      check_output("rst_out_last", int'(cur_out_last), 0);
      pix_cnt   = 0;
      exp_valid = 1'b0;
      exp_data  = 0;
      exp_last  = 1'b0;
    end else begin
      n = big ? 16 : 4;
      check_output("out_valid", int'(cur_out_valid), int'(exp_valid));
      check_output("in_ready", int'(cur_in_ready), int'(!exp_valid || out_ready));
      if (exp_valid) begin
        check_output("out_data", int'(cur_out_data), exp_data);
        check_output("out_last", int'(cur_out_last), int'(exp_last));
      end
      if (cur_out_valid && out_ready) begin
        got_d.push_back(int'(cur_out_data));
        got_l.push_back(cur_out_last);
      end
      acc = in_valid && (!exp_valid || out_ready);
      if (frame_clr) begin
        pix_cnt = 0;
        if (out_ready) exp_valid = 1'b0;
      end else begin
        if (acc) begin
          r = pix_cnt / n;
          c = pix_cnt % n;
          frame_px[pix_cnt] = int'(in_data);
          if ((r % 2 == 1) && (c % 2 == 1)) begin
            m = frame_px[(r-1)*n + c-1];
            if (frame_px[(r-1)*n + c] > m) m = frame_px[(r-1)*n + c];
            if (frame_px[r*n + c-1] > m) m = frame_px[r*n + c-1];
            if (frame_px[r*n + c] > m) m = frame_px[r*n + c];
            exp_valid = 1'b1;
            exp_data  = m;
            exp_last  = (pix_cnt == n*n - 1);
          end else if (out_ready) begin
            exp_valid = 1'b0;
          end
          pix_cnt = (pix_cnt == n*n - 1) ? 0 : pix_cnt + 1;
        end else if (out_ready) begin
          exp_valid = 1'b0;
        end
      end
    end
  end

  // Drive one pixel and hold it until the stage takes it, within a cycle budget.
  task automatic apply_stimulus(input logic [7:0] p);
    int   budget;
    logic ok;
    budget = 0;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = p;
    while (!ok && budget < 100) begin
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      ok = cur_in_ready;
      @(posedge clk);
      #1;
      budget++;
    end
    in_valid = 1'b0;
    if (!ok) check_output("accept_timeout", 0, 1);
    if (rand_gap) begin
      while ($urandom_range(0, 1) == 1) begin
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_reset();
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic check_window(input string name, input int base,
                              input int e0, input int e1, input int e2, input int e3);
    int e [4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    check_output({name, "_count"}, (got_d.size() >= base + 4) ? 1 : 0, 1);
    if (got_d.size() >= base + 4) begin
      for (int i = 0; i < 4; i++) begin
        check_output({name, "_data"}, got_d[base+i], e[i]);
        check_output({name, "_last"}, int'(got_l[base+i]), (i == 3) ? 1 : 0);
      end
    end
  endtask

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int t0;
    rst_n = 1'b0;
    #2;
    check_output("reset_out_valid", int'(out_valid4), 0);
    check_output("reset_out_data", int'(out_data4), 0);
    check_output("reset_in_ready", int'(in_ready4), 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Ramp frame with a free-flowing output.
    $display("[TB] ramp frame, out_ready high");
    got_d.delete(); got_l.delete();
    for (int i = 0; i < 16; i++) apply_stimulus(8'(i));
    drain();
    check_window("t1", 0, 5, 7, 13, 15);
    check_output("t1_total", got_d.size(), 4);

    // Constant frames back-to-back with no idle cycle at the boundary.
    $display("[TB] zero frame then full-scale frame");
    got_d.delete(); got_l.delete();
    t0 = cyc;
    for (int i = 0; i < 16; i++) apply_stimulus(8'd0);
    for (int i = 0; i < 16; i++) apply_stimulus(8'd255);
    check_output("t2_cycles", cyc - t0, 32);
    drain();
    check_window("t2a", 0, 0, 0, 0, 0);
    check_window("t2b", 4, 255, 255, 255, 255);

    // Downstream stalls from the first result onward.
    $display("[TB] stalled output");
    got_d.delete(); got_l.delete();
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) apply_stimulus(8'(i));
    in_valid = 1'b1;
    in_data  = 8'd6;
    repeat (4) begin
      @(negedge clk);
      check_output("t3_in_ready", int'(in_ready4), 0);
      check_output("t3_hold_data", int'(out_data4), 5);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    for (int i = 6; i < 16; i++) apply_stimulus(8'(i));
    drain();
    check_window("t3", 0, 5, 7, 13, 15);

    // Random data with random input gaps and random downstream readiness.
    $display("[TB] random frames");
    got_d.delete(); got_l.delete();
    rand_ready = 1'b1;
    rand_gap   = 1'b1;
    for (int f = 0; f < 100; f++) begin
      for (int i = 0; i < 16; i++) apply_stimulus(8'($urandom_range(0, 255)));
    end
    rand_ready = 1'b0;
    rand_gap   = 1'b0;
    drain();
    check_output("t4_count", got_d.size(), 400);

    // Abort a partial frame, then a reversed ramp must pool cleanly.
    $display("[TB] frame_clr mid-frame");
    for (int i = 0; i < 6; i++) apply_stimulus(8'(200 + i));
    drain();
    got_d.delete(); got_l.delete();
    frame_clr = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'd99;
    @(posedge clk);
    #1;
    frame_clr = 1'b0;
    in_valid  = 1'b0;
    for (int i = 15; i >= 0; i--) apply_stimulus(8'(i));
    drain();
    check_window("t5", 0, 15, 13, 7, 5);
    check_output("t5_total", got_d.size(), 4);

    // Asynchronous reset mid-frame with a result still held.
    $display("[TB] async reset mid-frame");
    for (int i = 0; i < 10; i++) apply_stimulus(8'(i));
    #2;
    rst_n = 1'b0;
    #1;
    check_output("t6_async_valid", int'(out_valid4), 0);
    check_output("t6_async_data", int'(out_data4), 0);
    check_output("t6_async_last", int'(out_last4), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    got_d.delete(); got_l.delete();
    for (int i = 0; i < 16; i++) apply_stimulus(8'(i));
    drain();
    check_window("t6", 0, 5, 7, 13, 15);

    // Same reset scenario on the full-size map.
    $display("[TB] 16x16 map");
    pulse_reset();
    big = 1'b1;
    pulse_reset();
    for (int i = 0; i < 10; i++) apply_stimulus(8'(i + 100));
    #2;
    rst_n = 1'b0;
    #1;
    check_output("t6b_async_valid", int'(out_valid16), 0);
    check_output("t6b_async_data", int'(out_data16), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    got_d.delete(); got_l.delete();
    for (int i = 0; i < 256; i++) apply_stimulus(8'(i));
    drain();
    check_output("t6b_count", got_d.size(), 64);
    if (got_d.size() == 64) begin
      check_output("t6b_first", got_d[0], 17);
      check_output("t6b_first_last", int'(got_l[0]), 0);
      check_output("t6b_final", got_d[63], 255);
      check_output("t6b_final_last", int'(got_l[63]), 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
